// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port, with bounded bursts per owner.
// Define FIFO_ARB_STATS_EN to add the saturating stall_cnt statistics output.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  // state   | meaning
  // IDLE    | no burst in progress; next grant comes from the round-robin scan
  // BURST   | owner holds the port until it drops req or uses MAX_BURST writes
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] burst_cnt;

  logic          cont;
  logic          has_cand;
  logic [PW-1:0] cand;
  logic          grant;

  always_comb begin : scan
    int idx;
    idx      = 0;
    cont     = (state == BURST) && req[owner] && (burst_cnt < CNT_MAX);
    has_cand = cont;
    cand     = owner;
    if (!cont) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!has_cand && req[idx]) begin
          has_cand = 1'b1;
          cand     = PW'(idx);
        end
      end
    end
  end

  // rst gates the outputs directly so nothing reaches the fifo while reset is high
  assign grant        = has_cand && !fifo_full && !rst;
  assign gnt          = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << cand) : '0;
  assign fifo_wr_en   = grant;
  assign fifo_data_in = grant ? wdata[int'(cand)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (grant) begin
      state <= BURST;
      if (cont) begin
        burst_cnt <= burst_cnt + CW'(1);
      end else begin
        owner     <= cand;
        burst_cnt <= CW'(1);
        rr_ptr    <= (cand == LAST_IDX) ? '0 : cand + PW'(1);
      end
    end else if (req == '0) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end
    // full with a pending candidate: everything holds so the burst resumes intact
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((|req) && fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
